// File: rtl/multiport_register_file_if.sv
// Bundle of read, write and reserve signals for multiport_register_file.
// master drives addresses/data/enables; slave returns read data and busy flags.
interface multiport_register_file_if #(
    parameter int D = 5,
    parameter int W = 32
);
    logic [D-1:0] rd_addr1;
    logic [D-1:0] rd_addr2;
    logic [W-1:0] rd_data1;
    logic [W-1:0] rd_data2;
    logic         rd_busy1;
    logic         rd_busy2;
    logic         wr_en0;
    logic         wr_en1;
    logic [D-1:0] wr_addr0;
    logic [D-1:0] wr_addr1;
    logic [W-1:0] wr_data0;
    logic [W-1:0] wr_data1;
    logic         rsv_en;
    logic [D-1:0] rsv_addr;
    logic         any_busy;

    modport master (
        output rd_addr1, rd_addr2, wr_en0, wr_en1, wr_addr0, wr_addr1,
               wr_data0, wr_data1, rsv_en, rsv_addr,
        input  rd_data1, rd_data2, rd_busy1, rd_busy2, any_busy
    );

    modport slave (
        input  rd_addr1, rd_addr2, wr_en0, wr_en1, wr_addr0, wr_addr1,
               wr_data0, wr_data1, rsv_en, rsv_addr,
        output rd_data1, rd_data2, rd_busy1, rd_busy2, any_busy
    );
endinterface

// File: rtl/multiport_register_file.sv
// Two-write / two-read register file with a per-register busy scoreboard,
// optional hardwired-zero register 0 and optional same-cycle write forwarding.
module multiport_register_file #(
    parameter int D        = 5,
    parameter int W        = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input logic                         clk,
    input logic                         rst_n,
    multiport_register_file_if.slave    bus
);
    localparam int   DEPTH     = 2 ** D;
    localparam logic ZERO_EN   = (ZERO_REG != 32'sd0);
    localparam logic BYPASS_EN = (BYPASS != 32'sd0);

    logic [W-1:0]     regs_r [DEPTH];
    logic [DEPTH-1:0] busy_r;

    logic         wr_ok0_s;
    logic         wr_ok1_s;
    logic         rsv_ok_s;
    logic [W-1:0] rd_data1_s;
    logic [W-1:0] rd_data2_s;
    logic         rd_busy1_s;
    logic         rd_busy2_s;

    // Address 0 is excluded from forwarding by the zero check, which comes first.
    function automatic logic [W-1:0] read_port(
        input logic [D-1:0] addr,
        input logic [W-1:0] stored,
        input logic         hit0,
        input logic [W-1:0] data0,
        input logic         hit1,
        input logic [W-1:0] data1
    );
        logic [W-1:0] value;
        if (ZERO_EN && (addr == '0)) begin
            value = '0;
        end else if (BYPASS_EN && hit1) begin
            value = data1;
        end else if (BYPASS_EN && hit0) begin
            value = data0;
        end else begin
            value = stored;
        end
        return value;
    endfunction

    // Write/reserve qualification: address 0 is read-only when hardwired to zero.
    always_comb begin
        wr_ok0_s = bus.wr_en0 && !(ZERO_EN && (bus.wr_addr0 == '0));
        wr_ok1_s = bus.wr_en1 && !(ZERO_EN && (bus.wr_addr1 == '0));
        rsv_ok_s = bus.rsv_en && !(ZERO_EN && (bus.rsv_addr == '0));
    end

    // Storage and scoreboard; later assignments win, so port 1 beats port 0 and reserve beats clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= '0;
            end
            busy_r <= '0;
        end else begin
            if (wr_ok0_s) begin
                regs_r[bus.wr_addr0] <= bus.wr_data0;
                busy_r[bus.wr_addr0] <= 1'b0;
            end
            if (wr_ok1_s) begin
                regs_r[bus.wr_addr1] <= bus.wr_data1;
                busy_r[bus.wr_addr1] <= 1'b0;
            end
            if (rsv_ok_s) begin
                busy_r[bus.rsv_addr] <= 1'b1;
            end
        end
    end

    // Zero-latency read ports; busy flags come straight from the stored vector.
    always_comb begin
        rd_data1_s = read_port(bus.rd_addr1, regs_r[bus.rd_addr1],
                               bus.wr_en0 && (bus.wr_addr0 == bus.rd_addr1), bus.wr_data0,
                               bus.wr_en1 && (bus.wr_addr1 == bus.rd_addr1), bus.wr_data1);
        rd_data2_s = read_port(bus.rd_addr2, regs_r[bus.rd_addr2],
                               bus.wr_en0 && (bus.wr_addr0 == bus.rd_addr2), bus.wr_data0,
                               bus.wr_en1 && (bus.wr_addr1 == bus.rd_addr2), bus.wr_data1);
        if (ZERO_EN && (bus.rd_addr1 == '0)) begin
            rd_busy1_s = 1'b0;
        end else begin
            rd_busy1_s = busy_r[bus.rd_addr1];
        end
        if (ZERO_EN && (bus.rd_addr2 == '0)) begin
            rd_busy2_s = 1'b0;
        end else begin
            rd_busy2_s = busy_r[bus.rd_addr2];
        end
    end

    assign bus.rd_data1 = rd_data1_s;
    assign bus.rd_data2 = rd_data2_s;
    assign bus.rd_busy1 = rd_busy1_s;
    assign bus.rd_busy2 = rd_busy2_s;
    assign bus.any_busy = |busy_r;

endmodule

// File: tb/tb_multiport_register_file.sv
// Randomized scoreboard bench: three register-file configurations share one stimulus stream
// and are checked against an array-based reference model.
module tb_multiport_register_file;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multiport_register_file_if #(.D(5), .W(32)) ifa ();
    multiport_register_file_if #(.D(5), .W(32)) ifb ();
    multiport_register_file_if #(.D(3), .W(8))  ifc ();

    multiport_register_file #(.D(5), .W(32), .ZERO_REG(1), .BYPASS(1)) u_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    multiport_register_file #(.D(5), .W(32), .ZERO_REG(0), .BYPASS(0)) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
    multiport_register_file #(.D(3), .W(8),  .ZERO_REG(1), .BYPASS(1)) u_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

    typedef struct {
        bit        rst_n;
        bit        we0;
        bit [4:0]  wa0;
        bit [31:0] wd0;
        bit        we1;
        bit [4:0]  wa1;
        bit [31:0] wd1;
        bit        rsv;
        bit [4:0]  ra;
        bit [4:0]  r1;
        bit [4:0]  r2;
    } stim_t;

    typedef struct {
        int        k;
        bit [31:0] d1;
        bit [31:0] d2;
        bit        b1;
        bit        b2;
        bit        ab;
    } exp_t;

    exp_t exp_q [$];
    int   pass_cnt = 0;
    int   total_cnt = 0;

    // Reference state: config 0 = zero+bypass, 1 = neither, 2 = small zero+bypass.
    bit [31:0] mem  [3][32];
    bit        bsy  [3][32];

    function automatic bit zr(int k);     return k != 1; endfunction
    function automatic bit bp(int k);     return k != 1; endfunction
    function automatic int amask(int k);  return (k == 2) ? 7 : 31; endfunction
    function automatic bit [31:0] dmask(int k); return (k == 2) ? 32'h0000_00FF : 32'hFFFF_FFFF; endfunction

    function automatic void model_clear();
        for (int k = 0; k < 3; k++)
            for (int a = 0; a < 32; a++) begin
                mem[k][a] = 32'h0;
                bsy[k][a] = 1'b0;
            end
    endfunction

    function automatic bit [31:0] model_read(int k, stim_t s, bit [4:0] addr);
        int a  = int'(addr) & amask(k);
        int a0 = int'(s.wa0) & amask(k);
        int a1 = int'(s.wa1) & amask(k);
        if (zr(k) && a == 0) return 32'h0;
        if (bp(k) && s.we1 && a1 == a) return s.wd1 & dmask(k);
        if (bp(k) && s.we0 && a0 == a) return s.wd0 & dmask(k);
        return mem[k][a];
    endfunction

    function automatic bit model_busy(int k, bit [4:0] addr);
        int a = int'(addr) & amask(k);
        if (zr(k) && a == 0) return 1'b0;
        return bsy[k][a];
    endfunction

    function automatic bit model_any(int k);
        bit r = 1'b0;
        for (int a = 0; a < 32; a++) r |= bsy[k][a];
        return r;
    endfunction

    function automatic void model_apply(int k, stim_t s);
        int a0 = int'(s.wa0) & amask(k);
        int a1 = int'(s.wa1) & amask(k);
        int ar = int'(s.ra) & amask(k);
        if (s.we0 && !(zr(k) && a0 == 0)) begin mem[k][a0] = s.wd0 & dmask(k); bsy[k][a0] = 1'b0; end
        if (s.we1 && !(zr(k) && a1 == 0)) begin mem[k][a1] = s.wd1 & dmask(k); bsy[k][a1] = 1'b0; end
        if (s.rsv && !(zr(k) && ar == 0)) bsy[k][ar] = 1'b1;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{rst_n: 1'b1, we0: 1'b0, wa0: 5'd0, wd0: 32'h0, we1: 1'b0, wa1: 5'd0, wd1: 32'h0,
              rsv: 1'b0, ra: 5'd0, r1: 5'd0, r2: 5'd0};
        return s;
    endfunction

    task automatic chk(string name, int k, bit [31:0] act, bit [31:0] expv);
        total_cnt++;
        if (act === expv) pass_cnt++;
        else $display("FAIL %s cfg%0d: got 0x%08h expected 0x%08h at %0t", name, k, act, expv, $time);
    endtask

    // Called at posedge+1: drive all configs, enqueue expectations, then advance one edge.
    task automatic drive(stim_t s);
        exp_t e;
        rst_n = s.rst_n;
        ifa.wr_en0 = s.we0; ifa.wr_addr0 = s.wa0; ifa.wr_data0 = s.wd0;
        ifa.wr_en1 = s.we1; ifa.wr_addr1 = s.wa1; ifa.wr_data1 = s.wd1;
        ifa.rsv_en = s.rsv; ifa.rsv_addr = s.ra; ifa.rd_addr1 = s.r1; ifa.rd_addr2 = s.r2;
        ifb.wr_en0 = s.we0; ifb.wr_addr0 = s.wa0; ifb.wr_data0 = s.wd0;
        ifb.wr_en1 = s.we1; ifb.wr_addr1 = s.wa1; ifb.wr_data1 = s.wd1;
        ifb.rsv_en = s.rsv; ifb.rsv_addr = s.ra; ifb.rd_addr1 = s.r1; ifb.rd_addr2 = s.r2;
        ifc.wr_en0 = s.we0; ifc.wr_addr0 = s.wa0[2:0]; ifc.wr_data0 = s.wd0[7:0];
        ifc.wr_en1 = s.we1; ifc.wr_addr1 = s.wa1[2:0]; ifc.wr_data1 = s.wd1[7:0];
        ifc.rsv_en = s.rsv; ifc.rsv_addr = s.ra[2:0]; ifc.rd_addr1 = s.r1[2:0]; ifc.rd_addr2 = s.r2[2:0];
        if (!s.rst_n) model_clear();
        for (int k = 0; k < 3; k++) begin
            e.k  = k;
            e.d1 = model_read(k, s, s.r1);
            e.d2 = model_read(k, s, s.r2);
            e.b1 = model_busy(k, s.r1);
            e.b2 = model_busy(k, s.r2);
            e.ab = model_any(k);
            exp_q.push_back(e);
        end
        @(posedge clk);
        if (s.rst_n)
            for (int k = 0; k < 3; k++) model_apply(k, s);
        #1;
    endtask

    // Monitor: outputs are settled at the falling edge; pop this cycle's expectations.
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.k)
                0: begin
                    chk("rd_data1", 0, ifa.rd_data1, e.d1);
                    chk("rd_data2", 0, ifa.rd_data2, e.d2);
                    chk("rd_busy1", 0, {31'h0, ifa.rd_busy1}, {31'h0, e.b1});
                    chk("rd_busy2", 0, {31'h0, ifa.rd_busy2}, {31'h0, e.b2});
                    chk("any_busy", 0, {31'h0, ifa.any_busy}, {31'h0, e.ab});
                end
                1: begin
                    chk("rd_data1", 1, ifb.rd_data1, e.d1);
                    chk("rd_data2", 1, ifb.rd_data2, e.d2);
                    chk("rd_busy1", 1, {31'h0, ifb.rd_busy1}, {31'h0, e.b1});
                    chk("rd_busy2", 1, {31'h0, ifb.rd_busy2}, {31'h0, e.b2});
                    chk("any_busy", 1, {31'h0, ifb.any_busy}, {31'h0, e.ab});
                end
                default: begin
                    chk("rd_data1", 2, {24'h0, ifc.rd_data1}, e.d1);
                    chk("rd_data2", 2, {24'h0, ifc.rd_data2}, e.d2);
                    chk("rd_busy1", 2, {31'h0, ifc.rd_busy1}, {31'h0, e.b1});
                    chk("rd_busy2", 2, {31'h0, ifc.rd_busy2}, {31'h0, e.b2});
                    chk("any_busy", 2, {31'h0, ifc.any_busy}, {31'h0, e.ab});
                end
            endcase
        end
    end

    initial begin
        stim_t s;
        int    drain;
        model_clear();
        @(posedge clk); #1;

        // Reset state
        s = idle(); s.rst_n = 1'b0; s.r1 = 5'd5; s.r2 = 5'd9; drive(s);

        // Write r5, reserve r9, then assert reset between edges
        s = idle(); s.we0 = 1'b1; s.wa0 = 5'd5; s.wd0 = 32'hDEAD_BEEF; s.rsv = 1'b1; s.ra = 5'd9; drive(s);
        s = idle(); s.r1 = 5'd5; s.r2 = 5'd9; drive(s);
        s = idle(); s.rst_n = 1'b0; s.r1 = 5'd5; s.r2 = 5'd9; drive(s);
        s = idle(); s.rst_n = 1'b0; s.we1 = 1'b1; s.wa1 = 5'd5; s.wd1 = 32'h0000_1234; s.r1 = 5'd5; drive(s);
        s = idle(); s.we0 = 1'b1; s.wa0 = 5'd6; s.wd0 = 32'h0000_0066; s.r1 = 5'd5; drive(s);
        s = idle(); s.r1 = 5'd6; s.r2 = 5'd5; drive(s);

        // Dual-write conflict on a reserved register
        s = idle(); s.rsv = 1'b1; s.ra = 5'd7; drive(s);
        s = idle(); s.we0 = 1'b1; s.wa0 = 5'd7; s.wd0 = 32'h11; s.we1 = 1'b1; s.wa1 = 5'd7; s.wd1 = 32'h22; s.r1 = 5'd7; s.r2 = 5'd7; drive(s);
        s = idle(); s.r1 = 5'd7; s.r2 = 5'd7; drive(s);

        // Zero register
        s = idle(); s.we0 = 1'b1; s.wa0 = 5'd0; s.wd0 = 32'hFFFF_FFFF; s.rsv = 1'b1; s.ra = 5'd0; drive(s);
        s = idle(); s.r1 = 5'd0; s.r2 = 5'd0; drive(s);

        // Bypass
        s = idle(); s.we0 = 1'b1; s.wa0 = 5'd3; s.wd0 = 32'h5; drive(s);
        s = idle(); s.we1 = 1'b1; s.wa1 = 5'd3; s.wd1 = 32'hA; s.r1 = 5'd3; drive(s);
        s = idle(); s.r1 = 5'd3; drive(s);

        // Scoreboard on r9
        s = idle(); s.rsv = 1'b1; s.ra = 5'd9; s.r1 = 5'd9; drive(s);
        s = idle(); s.r1 = 5'd9; drive(s);
        s = idle(); s.we0 = 1'b1; s.wa0 = 5'd9; s.wd0 = 32'h99; s.rsv = 1'b1; s.ra = 5'd9; s.r1 = 5'd9; drive(s);
        s = idle(); s.r1 = 5'd9; drive(s);
        s = idle(); s.we1 = 1'b1; s.wa1 = 5'd9; s.wd1 = 32'h98; s.r1 = 5'd9; drive(s);
        s = idle(); s.r1 = 5'd9; s.r2 = 5'd9; drive(s);

        // Fill-and-read sweep: distinct values in every low register
        for (int i = 0; i < 8; i++) begin
            s = idle(); s.we0 = 1'b1; s.wa0 = 5'(i); s.wd0 = 32'(i * 37 + 1); drive(s);
        end
        for (int i = 0; i < 8; i++) begin
            s = idle(); s.r1 = 5'(i); s.r2 = 5'(7 - i); drive(s);
        end

        // Randomized traffic, narrow address range to provoke collisions
        for (int n = 0; n < 400; n++) begin
            s = idle();
            s.rst_n = ($urandom_range(0, 59) != 0);
            s.we0 = $urandom_range(0, 1); s.wa0 = 5'($urandom_range(0, 11)); s.wd0 = $urandom;
            s.we1 = $urandom_range(0, 1); s.wa1 = 5'($urandom_range(0, 11)); s.wd1 = $urandom;
            s.rsv = $urandom_range(0, 1); s.ra = 5'($urandom_range(0, 11));
            s.r1 = 5'($urandom_range(0, 11)); s.r2 = 5'($urandom_range(0, 31));
            drive(s);
        end

        drain = 0;
        while (exp_q.size() > 0 && drain < 5) begin
            @(posedge clk);
            drain++;
        end
        if (exp_q.size() > 0) begin
            total_cnt++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/multiport_register_file.md
MULTIPORT_REGISTER_FILE -- requirements
Module: multiport_register_file

Interface
REQ-001 SHALL have parameter D, default 5, address width; depth is 2**D registers.
REQ-002 SHALL have parameter W, default 32, bits per register.
REQ-003 SHALL have parameter ZERO_REG, default 1; when 1, register 0 always reads 0.
REQ-004 SHALL have parameter BYPASS, default 1; when 1, same-cycle write data is forwarded to the read ports.
REQ-005 SHALL have one clock and an asynchronous, active-low reset; both are listed first.
REQ-006 clk  in  1  clock; all state updates on rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 rd_addr1, rd_addr2  in  D  read port addresses.
REQ-009 rd_data1, rd_data2  out  W  combinational read data.
REQ-010 rd_busy1, rd_busy2  out  1  pending-write (scoreboard) flag of the addressed register.
REQ-011 wr_en0, wr_en1  in  1  write enables, ports 0 and 1.
REQ-012 wr_addr0, wr_addr1  in  D  write addresses.
REQ-013 wr_data0, wr_data1  in  W  write data.
REQ-014 rsv_en  in  1  reserve request; marks the register at rsv_addr as busy.
REQ-015 rsv_addr  in  D  reserve address.
REQ-016 any_busy  out  1  OR of all busy bits.

Function
REQ-017 Storage: 2**D x W array plus a 2**D-bit busy vector.
REQ-018 Write: on a rising edge with wr_enN=1, reg[wr_addrN] <= wr_dataN; the write also clears busy[wr_addrN].
REQ-019 Write conflict: if wr_en0 and wr_en1 target the same address, port 1 wins; the stored data is wr_data1.
REQ-020 Zero register: with ZERO_REG=1, writes and reserves to address 0 are ignored; rd_data is 0 and rd_busy is 0 for address 0.
REQ-021 Read: rd_dataN = reg[rd_addrN], with zero read latency.
REQ-022 Bypass: with BYPASS=1 and rd_addrN matching an active write address, rd_dataN shows that write data in the same cycle, with port 1 taking priority; addr-0 suppression under ZERO_REG still applies.
REQ-023 Bypass is off when BYPASS=0; the read returns the pre-write value until the next cycle.
REQ-024 Reserve: on a rising edge with rsv_en=1, busy[rsv_addr] <= 1.
REQ-025 Reserve and write to the same address in the same cycle: reserve wins, so busy stays 1 and the data is still written.
REQ-026 rd_busyN = busy[rd_addrN], with no bypass of same-cycle reserve or clear.
REQ-027 any_busy is 1 when any busy bit is 1.
REQ-028 Reading an address not being written has no side effects; simultaneous read and write of different addresses are independent.

Reset
REQ-029 When rst_n=0, all registers SHALL clear to 0 and all busy bits to 0 immediately, without waiting for clk.
REQ-030 While rst_n=0, writes and reserves SHALL be ignored; rd_data outputs read 0 unless bypassed, any_busy=0.
REQ-031 Reset asserted mid-write SHALL leave the target register at 0 after reset release.
REQ-032 The first rising edge with rst_n=1 SHALL perform normal writes and reserves.

Verification
REQ-033 Reset: write 0xDEADBEEF to r5, assert rst_n=0 between edges -> rd_data1(r5)=0 immediately and any_busy=0.
REQ-034 Dual write conflict: wr0 r7=0x11, wr1 r7=0x22 on the same edge -> next cycle rd r7=0x22; busy[7] cleared.
REQ-035 Zero register: write r0=0xFFFFFFFF, rsv r0 -> rd r0=0 and rd_busy=0 (ZERO_REG=1); with ZERO_REG=0 -> 0xFFFFFFFF and busy=1.
REQ-036 Bypass: r3=0x5; in a cycle with wr1 r3=0xA and rd_addr1=3 -> rd_data1=0xA pre-edge with BYPASS=1, and 0x5 with BYPASS=0.
REQ-037 Scoreboard: rsv r9 -> rd_busy(r9)=1 next cycle and any_busy=1; write r9 together with rsv r9 -> stays 1; later write r9 alone -> 0 and any_busy=0.
REQ-038 Parameter sweep: D=3 and W=8 -> all 8 registers are written and read back with distinct values, no aliasing.
